adc_arbiter: RTL and testbench

ADC_ARBITER -- requirements
Module: adc_arbiter

---
 rtl/adc_arbiter.sv | 179 +++++++++++++++++
 tb/tb_adc_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/adc_arbiter.sv
// adc_arbiter -- round-robin arbiter that shares one ADC between four
// requesters. Requester i owns analog mux channel i. A transaction walks
// IDLE -> SETTLE -> START -> WAIT -> RESP -> IDLE.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_req[3:0]     level request per requester
//   o_ack[3:0]     one-hot, one-cycle completion pulse to the served requester
//   o_result       conversion value, valid with o_ack, held until next ack
//   o_err          set with o_ack when the conversion timed out
//   o_mux_sel      analog mux channel select
//   o_conv_start   one-cycle pulse requesting a conversion
//   i_conv_done    one-cycle pulse from the ADC front-end
//   i_conv_value   ADC sample, valid with i_conv_done
//   o_busy         high whenever the FSM is not in IDLE
//
// The ack/result/err/conv_start outputs are registered off the state, so
// they appear one cycle after the state that produces them. That gives
// req-rise to conv_start = SETTLE_CYCLES+2 and conv_done to ack = 2.
module adc_arbiter #(
  parameter int ADC_WIDTH      = 12,
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [3:0]           i_req,
  output logic [3:0]           o_ack,
  output logic [ADC_WIDTH-1:0] o_result,
  output logic                 o_err,
  output logic [1:0]           o_mux_sel,
  output logic                 o_conv_start,
  input  logic                 i_conv_done,
  input  logic [ADC_WIDTH-1:0] i_conv_value,
  output logic                 o_busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_START, S_WAIT, S_RESP
  } state_t;

  // Counters load N-1 and run down to 0, so each phase lasts exactly N cycles.
  localparam logic [7:0]  SET_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYCLES - 1);

  state_t               r_state, w_state_nxt;
  logic [1:0]           r_grant;
  logic [1:0]           r_rr;
  logic [7:0]           r_set_cnt;
  logic [15:0]          r_tmo_cnt;
  logic [ADC_WIDTH-1:0] r_cap_val;
  logic                 r_cap_err;

  logic [3:0]           r_ack;
  logic [ADC_WIDTH-1:0] r_result;
  logic                 r_err;
  logic [1:0]           r_mux_sel;
  logic                 r_conv_start;

  logic                 w_any;
  logic [1:0]           w_pick;
  logic [1:0]           w_idx;
  logic [3:0]           w_ack_nxt;
  logic [ADC_WIDTH-1:0] w_result_nxt;
  logic                 w_err_nxt;
  logic                 w_conv_start_nxt;

  // Round-robin pick: scan offsets high to low so the smallest offset from
  // r_rr that has a request wins.
  assign w_any = |i_req;

  always_comb begin
    w_pick = r_rr;
    w_idx  = r_rr;
    for (int i = 3; i >= 0; i--) begin
      w_idx = r_rr + 2'(i);
      if (i_req[w_idx]) w_pick = w_idx;
    end
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_any) w_state_nxt = S_SETTLE;
      S_SETTLE: if (r_set_cnt == 8'd0) w_state_nxt = S_START;
      S_START:  w_state_nxt = S_WAIT;
      // A done in the expiry cycle still leaves through here as a success.
      S_WAIT:   if (i_conv_done || r_tmo_cnt == 16'd0) w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Grant, counters and conversion capture
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_grant   <= 2'd0;
      r_rr      <= 2'd0;
      r_mux_sel <= 2'd0;
      r_set_cnt <= 8'd0;
      r_tmo_cnt <= 16'd0;
      r_cap_val <= '0;
      r_cap_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant   <= w_pick;
            r_mux_sel <= w_pick;
            r_set_cnt <= SET_LOAD;
          end
        end
        S_SETTLE: if (r_set_cnt != 8'd0) r_set_cnt <= r_set_cnt - 8'd1;
        S_START:  r_tmo_cnt <= TMO_LOAD;
        S_WAIT: begin
          if (i_conv_done) begin
            r_cap_val <= i_conv_value;
            r_cap_err <= 1'b0;
          end else if (r_tmo_cnt == 16'd0) begin
            r_cap_val <= '0;
            r_cap_err <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt - 16'd1;
          end
        end
        // Served requester drops to lowest priority for the next pick.
        S_RESP:   r_rr <= r_grant + 2'd1;
        default:  ;
      endcase
    end
  end

  // Output logic (next values of the registered outputs)
  always_comb begin
    w_ack_nxt        = 4'd0;
    w_result_nxt     = r_result;
    w_err_nxt        = r_err;
    w_conv_start_nxt = 1'b0;
    case (r_state)
      S_START: w_conv_start_nxt = 1'b1;
      S_RESP: begin
        w_ack_nxt    = 4'b0001 << r_grant;
        w_result_nxt = r_cap_val;
        w_err_nxt    = r_cap_err;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ack        <= 4'd0;
      r_result     <= '0;
      r_err        <= 1'b0;
      r_conv_start <= 1'b0;
    end else begin
      r_ack        <= w_ack_nxt;
      r_result     <= w_result_nxt;
      r_err        <= w_err_nxt;
      r_conv_start <= w_conv_start_nxt;
    end
  end

  assign o_ack        = r_ack;
  assign o_result     = r_result;
  assign o_err        = r_err;
  assign o_mux_sel    = r_mux_sel;
  assign o_conv_start = r_conv_start;
  assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_adc_arbiter.sv
module tb_adc_arbiter;
  localparam int S = 8;
  localparam int T = 24;
  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req = 4'd0;
  logic [3:0]   ack;
  logic [W-1:0] result;
  logic         err;
  logic [1:0]   mux_sel;
  logic         conv_start;
  logic         conv_done = 1'b0;
  logic [W-1:0] conv_value = '0;
  logic         busy;

  adc_arbiter #(.ADC_WIDTH(W), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .o_ack(ack), .o_result(result),
    .o_err(err), .o_mux_sel(mux_sel), .o_conv_start(conv_start),
    .i_conv_done(conv_done), .i_conv_value(conv_value), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int           n_chk = 0;
  int           n_fail = 0;
  int           rr_m = 0;
  logic [W-1:0] prev_res = '0;
  logic         prev_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // First requester at or after the pointer, wrapping 3->0.
  function automatic int ref_grant(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  // One transaction from an IDLE arbiter. d = cycles from conv_start to the
  // conv_done pulse (d >= T means none inside WAIT). rst_at > 0 resets the
  // DUT that many cycles into WAIT and abandons the transaction.
  task automatic do_txn(input logic [3:0] pat, input int d, input logic [W-1:0] val,
                        input bit drop, input bit spur, input int rst_at);
    int g, cnt, sp, exp_lat;
    bit quiet, ok;
    g  = ref_grant(pat, rr_m);
    sp = spur ? int'($urandom_range(S, 0)) : -1;
    req = pat;
    conv_value = val;
    conv_done = (sp == 0);
    cnt = 0; quiet = 1;
    while (cnt < 4 * S + 10) begin
      @(posedge clk); @(negedge clk); cnt++;
      if (conv_start) break;
      if (ack !== 4'd0 || result !== prev_res || err !== prev_err) quiet = 0;
      if (drop && cnt == 1) req = 4'd0;
      conv_done = (cnt == sp);
    end
    conv_done = 1'b0;
    chk("quiet_pre_start", quiet, 1);
    chk("start_latency", cnt, S + 2);
    chk("mux_sel", mux_sel, g);
    chk("busy_wait", busy, 1);

    cnt = 0; quiet = 1;
    while (cnt < T + 10) begin
      @(posedge clk); @(negedge clk); cnt++;
      if (cnt == rst_at) begin
        rst_n = 1'b0;
        req = 4'd0;
        #1;
        ok = (ack == 4'd0) && (result == '0) && (err == 1'b0) && (mux_sel == 2'd0)
             && (conv_start == 1'b0) && (busy == 1'b0);
        chk("reset_mid_wait", ok, 1);
        rr_m = 0; prev_res = '0; prev_err = 1'b0;
        return;
      end
      if (ack !== 4'd0) break;
      if (conv_start !== 1'b0 || busy !== 1'b1) quiet = 0;
      conv_done = (cnt == d);
    end
    conv_done = 1'b0;
    exp_lat = (d <= T - 1) ? d + 2 : T + 1;
    chk("quiet_wait", quiet, 1);
    chk("ack_latency", cnt, exp_lat);
    chk("ack_onehot", ack, 32'd1 << g);
    chk("no_start_with_ack", conv_start, 0);
    chk("result", result, (d <= T - 1) ? val : '0);
    chk("err", err, (d <= T - 1) ? 0 : 1);
    prev_res = (d <= T - 1) ? val : '0;
    prev_err = (d <= T - 1) ? 1'b0 : 1'b1;
    rr_m = (g + 1) % 4;
  endtask

  initial begin
    logic [W-1:0] v;
    logic [3:0]   p;
    bit           ok;

    repeat (3) @(negedge clk);
    ok = (ack == 4'd0) && (result == '0) && (err == 1'b0) && (mux_sel == 2'd0)
         && (conv_start == 1'b0) && (busy == 1'b0);
    chk("reset_state", ok, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // All requesting after reset: 0 first, then round robin 1,2,3,0.
    for (int k = 0; k < 5; k++) do_txn(4'b1111, 3 + k, W'(12'h100 + k), 0, 0, -1);
    // Pointer now at 1: 1001 serves 3, 0, 3.
    do_txn(4'b1001, 4, 12'h333, 0, 0, -1);
    do_txn(4'b1001, 6, 12'h444, 0, 0, -1);
    do_txn(4'b1001, 7, 12'h555, 1, 0, -1);

    // Single request, value captured 20 cycles after conv_start.
    do_txn(4'b0100, 20, 12'hA5C, 1, 0, -1);
    // Timeout (a late done in RESP is ignored), then a good one clears err.
    do_txn(4'b0001, T, 12'hFFF, 1, 0, -1);
    do_txn(4'b0001, 5, 12'h123, 1, 0, -1);
    // Done coincident with expiry wins; spurious done during IDLE/SETTLE.
    do_txn(4'b0010, T - 1, 12'h7FF, 1, 1, -1);

    for (int k = 0; k < 20; k++) begin
      p = 4'($urandom_range(15, 1));
      v = W'($urandom);
      do_txn(p, int'($urandom_range(T, 1)), v, bit'($urandom_range(1, 0)),
             bit'($urandom_range(1, 0)), -1);
    end

    // Reset 5 cycles into WAIT, stray done afterwards, then requester 1.
    do_txn(4'b0100, 100, 12'h999, 0, 0, 5);
    @(negedge clk);
    rst_n = 1'b1;
    conv_done = 1'b1;
    @(negedge clk);
    conv_done = 1'b0;
    ok = 1;
    repeat (4) begin
      @(negedge clk);
      if (ack !== 4'd0 || busy !== 1'b0 || result !== '0) ok = 0;
    end
    chk("ignore_done_after_reset", ok, 1);
    do_txn(4'b0010, 9, 12'h2B6, 1, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
